// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the synchronous ROM address,
// and hands a registered PC/instruction pair to ID through a one-entry skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000,
    parameter int unsigned ROM_AW   = 14
) (
    input  logic              sysclk,
    input  logic              nrst,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    input  logic              halt_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic [31:0]       pc_id_o,
    output logic [31:0]       iword_id_o,
    output logic              valid_id_o,
    output logic              fault_o
);

    typedef enum logic {
        MODE_RUN,
        MODE_HALTED
    } mode_e;

    mode_e       mode_q, mode_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic        inflight_v_q, inflight_v_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        hold_v_q, hold_v_d;
    logic [31:0] hold_word_q, hold_word_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] iword_id_q, iword_id_d;
    logic        valid_id_q, valid_id_d;
    logic        fault_q, fault_d;

    logic        redirect_misaligned;

    assign redirect_misaligned = |redirect_pc_i[1:0];

    always_comb begin
        mode_d        = mode_q;
        pc_f_d        = pc_f_q;
        inflight_v_d  = inflight_v_q;
        inflight_pc_d = inflight_pc_q;
        hold_v_d      = hold_v_q;
        hold_word_d   = hold_word_q;
        pc_id_d       = pc_id_q;
        iword_id_d    = iword_id_q;
        valid_id_d    = valid_id_q;
        fault_d       = fault_q;

        if (mode_q == MODE_RUN) begin
            if (redirect_i) begin
                if (redirect_misaligned) begin
                    fault_d = 1'b1;
                    mode_d  = MODE_HALTED;
                end else begin
                    pc_f_d = redirect_pc_i;
                end
                inflight_v_d = 1'b0;
                hold_v_d     = 1'b0;
                pc_id_d      = '0;
                iword_id_d   = '0;
                valid_id_d   = 1'b0;
            end else if (halt_i) begin
                mode_d       = MODE_HALTED;
                inflight_v_d = 1'b0;
                hold_v_d     = 1'b0;
                pc_id_d      = '0;
                iword_id_d   = '0;
                valid_id_d   = 1'b0;
            end else if (stall_i) begin
                // ROM data for the in-flight PC is only on the bus for this cycle; park it.
                if (!hold_v_q && inflight_v_q) begin
                    hold_word_d = rom_data_i;
                    hold_v_d    = 1'b1;
                end
            end else begin
                pc_f_d        = pc_f_q + 32'd4;
                inflight_pc_d = pc_f_q;
                inflight_v_d  = 1'b1;
                valid_id_d    = inflight_v_q;
                hold_v_d      = 1'b0;
                if (inflight_v_q) begin
                    pc_id_d    = inflight_pc_q;
                    iword_id_d = hold_v_q ? hold_word_q : rom_data_i;
                end else begin
                    pc_id_d    = '0;
                    iword_id_d = '0;
                end
            end
        end
    end

    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            mode_q        <= MODE_RUN;
            pc_f_q        <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            hold_v_q      <= 1'b0;
            hold_word_q   <= '0;
            pc_id_q       <= '0;
            iword_id_q    <= '0;
            valid_id_q    <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            pc_f_q        <= pc_f_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            hold_v_q      <= hold_v_d;
            hold_word_q   <= hold_word_d;
            pc_id_q       <= pc_id_d;
            iword_id_q    <= iword_id_d;
            valid_id_q    <= valid_id_d;
            fault_q       <= fault_d;
        end
    end

    assign rom_addr_o = pc_f_q[ROM_AW+1:2];
    assign pc_id_o    = pc_id_q;
    assign iword_id_o = iword_id_q;
    assign valid_id_o = valid_id_q;
    assign fault_o    = fault_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 5-stage pipeline, directly upstream of the decoder. It owns the fetch PC and drives the word address of the synchronous instruction ROM, which returns data one cycle after the address. It delivers a registered PC/instruction pair to the ID stage. It handles ID-side stall back-pressure with a one-entry skid buffer, branch redirects from EX with bubble insertion, halt, and misaligned-target faults.

## Interface
- RESET_PC, 32'h8000, fetch PC loaded at reset.
- ROM_AW, 14, ROM word-address width; ROM address is PC[ROM_AW+1:2].
- sysclk  in  1  sole clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- stall_i  in  1  ID cannot accept; hold ID outputs.
- redirect_i  in  1  taken branch/jump resolved in EX.
- redirect_pc_i  in  32  redirect target.
- halt_i  in  1  halt instruction reached EX; stop fetching.
- rom_addr_o  out  ROM_AW  ROM word address; registered, equals pc_f[ROM_AW+1:2].
- rom_data_i  in  32  ROM word for the address presented on the previous edge.
- pc_id_o  out  32  PC of the instruction delivered to ID.
- iword_id_o  out  32  instruction delivered to ID; 32'h0 when invalid.
- valid_id_o  out  1  pc_id_o and iword_id_o are a real instruction.
- fault_o  out  1  sticky: a redirect target was misaligned.

## Operation
- Internal state:
  - pc_f: address being presented to the ROM.
  - inflight_v / inflight_pc: the PC whose data is on rom_data_i this cycle.
  - hold_v / hold_word: skid buffer.
  - mode: RUN or HALTED.
- Priority per edge: reset > redirect_i > halt_i > stall_i > normal advance.
- Normal advance (RUN, no stall):
  - pc_f <= pc_f+4; inflight_pc <= pc_f; inflight_v <= 1.
  - pc_id <= inflight_pc; iword_id <= hold_v ? hold_word : rom_data_i; valid_id <= inflight_v; hold_v <= 0.
  - When inflight_v=0, iword_id <= 0 and pc_id <= 0.
- Stall (stall_i=1, no redirect):
  - pc_f, inflight_*, and the ID outputs all hold.
  - If hold_v=0 and inflight_v=1: hold_word <= rom_data_i; hold_v <= 1.
  - While stalled, the ROM keeps reading pc_f, so after release the ROM data matches the newly issued inflight_pc.
- Redirect (overrides stall):
  - If redirect_pc_i[1:0]==0: pc_f <= redirect_pc_i.
  - Otherwise: fault_o <= 1 and mode <= HALTED.
  - In both cases: inflight_v <= 0; hold_v <= 0; pc_id <= 0; iword_id <= 0; valid_id <= 0.
- Halt: mode <= HALTED.
  - inflight_v <= 0 and hold_v <= 0.
  - pc_f freezes.
  - The ID outputs take one final bubble (valid_id <= 0, pc_id <= 0, iword_id <= 0), even if stall_i=1.
  - HALTED exits only on reset. Further redirects in HALTED are ignored, and fault_o does not change.
- PC arithmetic is modulo 2^32; pc_f wraps 32'hFFFFFFFC -> 0. rom_addr_o wraps naturally at the ROM size.

## Timing
- Reset values:
  - pc_f=RESET_PC, so rom_addr_o=RESET_PC[ROM_AW+1:2] (0x2000 at defaults).
  - inflight_v=0, hold_v=0, mode=RUN.
  - pc_id_o=0, iword_id_o=0, valid_id_o=0, fault_o=0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Startup: 1st edge after nrst rises sets inflight_v. 2nd edge gives valid_id_o=1 with pc_id_o=RESET_PC.
- Throughput: one instruction per cycle absent stall or redirect.
- Redirect at edge N: outputs are a bubble after N and N+1. The target is on the ID outputs after edge N+2, giving 2 bubbles.
- Stall release: the instruction held in the skid buffer is delivered on the first unstalled edge. No instruction is lost or duplicated for any stall length ≥1.
- Redirect and stall in the same cycle: redirect wins, and the ID outputs are bubbled.

## Test plan
- Reset with ROM[i]=i+0x100: release nrst -> valid_id_o rises after the 2nd edge, then pc_id_o = 0x8000, 0x8004, 0x8008 with iword 0x2100, 0x2101, 0x2102.
- Stall_i high 3 cycles at pc_id 0x8004 -> ID outputs hold 0x8004. After release the sequence is 0x8008, 0x800C, with no gap, skip, or duplicate.
- redirect_i with 0x8100 while streaming -> 2 bubbles (valid 0, iword 0), then pc_id 0x8100 followed by 0x8104.
- redirect_i with 0x8102 -> fault_o=1 and stays 1. valid_id_o stays 0 indefinitely, and rom_addr_o freezes.
- halt_i during streaming -> one bubble on the ID outputs, then no further valid instructions. A later redirect is ignored. nrst low then high -> restart at 0x8000.
- Simultaneous redirect_i=1 (0x8200) and stall_i=1 -> bubble on the next edge. With stall released, 0x8200 arrives 2 edges later.
- Assert nrst mid-stall with hold_v=1 -> all outputs return to reset values asynchronously, and the buffered word is never delivered.
